// File: rtl/prbs5_checker.sv
// rtl/prbs5_checker.sv - serial PRBS5 checker with seed/sync/lock FSM, window-based loss detection and error/bit counters
module prbs5_checker #(
    parameter int LOCK_THRESH = 8,
    parameter int LOSS_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_valid,
    input  logic        din,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [15:0] bit_count
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [4:0] LOCK_T = 5'(LOCK_THRESH);
    localparam logic [5:0] LOSS_T = 6'(LOSS_THRESH);

    state_t      state_q, state_d;
    logic [4:0]  hist_q, hist_d;
    logic [2:0]  seed_cnt_q, seed_cnt_d;
    logic [3:0]  match_cnt_q, match_cnt_d;
    logic [4:0]  win_cnt_q, win_cnt_d;
    logic [4:0]  win_err_q, win_err_d;
    logic        locked_q, locked_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] err_count_q, err_count_d;
    logic [15:0] bit_count_q, bit_count_d;

    logic        pred;
    logic        mismatch;
    logic [4:0]  hist_shift_din;
    logic [4:0]  match_inc;
    logic [5:0]  win_err_inc;

    // Next-state logic: prediction, history shift, lock/loss decisions and counters
    always_comb begin
        pred           = hist_q[2] ^ hist_q[4];
        mismatch       = din ^ pred;
        hist_shift_din = {hist_q[3:0], din};
        match_inc      = {1'b0, match_cnt_q} + 5'd1;
        win_err_inc    = {1'b0, win_err_q} + {5'd0, mismatch};

        state_d     = state_q;
        hist_d      = hist_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;

        if (din_valid) begin
            case (state_q)
                SEED: begin
                    hist_d = hist_shift_din;
                    if (seed_cnt_q == 3'd4) begin
                        state_d     = SYNC;
                        seed_cnt_d  = 3'd0;
                        match_cnt_d = 4'd0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 3'd1;
                    end
                end
                SYNC: begin
                    // Received bit always enters the history so the checker self-synchronises
                    hist_d = hist_shift_din;
                    if (mismatch || (hist_shift_din == 5'd0)) begin
                        match_cnt_d = 4'd0;
                    end else begin
                        match_cnt_d = match_inc[3:0];
                        if (match_inc == LOCK_T) begin
                            state_d   = LOCKED;
                            win_cnt_d = 5'd0;
                            win_err_d = 5'd0;
                        end
                    end
                end
                LOCKED: begin
                    // Prediction enters the history so a received error cannot poison later bits
                    hist_d = {hist_q[3:0], pred};
                    if (bit_count_q != 16'hFFFF) begin
                        bit_count_d = bit_count_q + 16'd1;
                    end
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end
                    if (win_err_inc >= LOSS_T) begin
                        state_d     = SEED;
                        hist_d      = 5'd0;
                        seed_cnt_d  = 3'd0;
                        match_cnt_d = 4'd0;
                        win_cnt_d   = 5'd0;
                        win_err_d   = 5'd0;
                    end else if (win_cnt_q == 5'd30) begin
                        win_cnt_d = 5'd0;
                        win_err_d = 5'd0;
                    end else begin
                        win_cnt_d = win_cnt_q + 5'd1;
                        win_err_d = win_err_inc[4:0];
                    end
                end
                default: begin
                    state_d = SEED;
                end
            endcase
        end

        if (clear_cnt) begin
            err_count_d = 16'd0;
            bit_count_d = 16'd0;
        end

        locked_d = (state_d == LOCKED);
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            hist_q      <= 5'd0;
            seed_cnt_q  <= 3'd0;
            match_cnt_q <= 4'd0;
            win_cnt_q   <= 5'd0;
            win_err_q   <= 5'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= 16'd0;
            bit_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs5_checker.sv
// tb/tb_prbs5_checker.sv - scoreboard bench for prbs5_checker with directed and random stimulus
module tb_prbs5_checker;

    localparam int LT = 8;
    localparam int LS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] bit_count;

    always #5 clk = ~clk;

    prbs5_checker #(.LOCK_THRESH(LT), .LOSS_THRESH(LS)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    typedef struct {
        bit lk;
        bit ep;
        int ec;
        int bc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // reference model: mode 0 = seeding, 1 = hunting, 2 = locked
    int   mode = 0;
    bit   h[$];
    int   mc = 0, wc = 0, we = 0, ec = 0, bc = 0;
    bit   ep = 0;

    // transmitter
    bit       txh[$];
    bit [4:0] seed = 5'b10101;

    function automatic bit prbs_next();
        bit b;
        if (txh.size() < 5) b = seed[4 - txh.size()];
        else                b = txh[2] ^ txh[0];
        txh.push_back(b);
        if (txh.size() > 5) void'(txh.pop_front());
        return b;
    endfunction

    task automatic model(input bit v, input bit d, input bit c, input bit r);
        bit p;
        bit zero;
        ep = 0;
        if (r) begin
            mode = 0; h.delete(); mc = 0; wc = 0; we = 0; ec = 0; bc = 0;
        end else begin
            if (v) begin
                if (mode == 0) begin
                    h.push_back(d);
                    if (h.size() == 5) begin mode = 1; mc = 0; end
                end else begin
                    p = h[2] ^ h[0];
                    if (mode == 1) begin
                        h.push_back(d);
                        void'(h.pop_front());
                        zero = 1;
                        foreach (h[i]) if (h[i]) zero = 0;
                        mc = (d == p && !zero) ? mc + 1 : 0;
                        if (mc == LT) begin mode = 2; wc = 0; we = 0; end
                    end else begin
                        h.push_back(p);
                        void'(h.pop_front());
                        if (bc < 65535) bc++;
                        if (d != p) begin
                            ep = 1;
                            if (ec < 65535) ec++;
                            we++;
                        end
                        if (we >= LS) begin
                            mode = 0; h.delete(); mc = 0; wc = 0; we = 0;
                        end else if (wc == 30) begin
                            wc = 0; we = 0;
                        end else begin
                            wc++;
                        end
                    end
                end
            end
            if (c) begin ec = 0; bc = 0; end
        end
    endtask

    task automatic step(input bit v, input bit d, input bit c, input bit r);
        exp_t e;
        @(negedge clk);
        din_valid = v; din = d; clear_cnt = c; rst = r;
        model(v, d, c, r);
        e.lk = (mode == 2); e.ep = ep; e.ec = ec; e.bc = bc;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp_v);
        end
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(1, prbs_next(), 0, 0);
    endtask

    task automatic flip();
        step(1, !prbs_next(), 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        txh.delete();
    endtask

    // monitor: every cycle the DUT presents registered outputs; compare against the queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (locked !== mon_e.lk || err_pulse !== mon_e.ep ||
                    err_count !== 16'(mon_e.ec) || bit_count !== 16'(mon_e.bc)) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got lk=%0b ep=%0b ec=%0d bc=%0d expected lk=%0b ep=%0b ec=%0d bc=%0d",
                             $time, locked, err_pulse, err_count, bit_count,
                             mon_e.lk, mon_e.ep, mon_e.ec, mon_e.bc);
                end
            end
        end
    end

    initial begin
        bit v, d, c, r;

        // reset state
        do_reset();
        settle();
        chk("reset_locked", int'(locked), 0);
        chk("reset_err_count", int'(err_count), 0);
        chk("reset_bit_count", int'(bit_count), 0);

        // clean stream from seed 10101: lock after valid bit 13
        clean(12);
        settle();
        chk("no_lock_after_12", int'(locked), 0);
        clean(1);
        settle();
        chk("lock_after_13", int'(locked), 1);
        clean(100);
        settle();
        chk("clean_err_count", int'(err_count), 0);
        chk("clean_bit_count", int'(bit_count), 100);

        // single inverted bit
        clean(5);
        flip();
        settle();
        chk("single_err_pulse", int'(err_pulse), 1);
        chk("single_err_count", int'(err_count), 1);
        chk("single_locked", int'(locked), 1);
        clean(1);
        settle();
        chk("single_pulse_width", int'(err_pulse), 0);
        clean(40);
        settle();
        chk("single_no_more_errs", int'(err_count), 1);

        // four errors in one window -> loss, relock after 13 clean bits
        step(0, 0, 1, 0);
        flip(); clean(1); flip(); clean(1); flip(); clean(1);
        settle();
        chk("three_errs_still_locked", int'(locked), 1);
        flip();
        settle();
        chk("fourth_err_loss", int'(locked), 0);
        chk("loss_err_count", int'(err_count), 4);
        clean(12);
        settle();
        chk("relock_not_early", int'(locked), 0);
        clean(1);
        settle();
        chk("relock", int'(locked), 1);
        chk("relock_err_kept", int'(err_count), 4);

        // all-zero stream never locks
        do_reset();
        for (int i = 0; i < 200; i++) step(1, 0, 0, 0);
        settle();
        chk("zeros_no_lock", int'(locked), 0);
        chk("zeros_err_count", int'(err_count), 0);

        // din_valid toggling every cycle
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(1, prbs_next(), 0, 0);
            if (i == 11) begin settle(); chk("toggle_no_lock_12", int'(locked), 0); end
            if (i == 12) begin settle(); chk("toggle_lock_13", int'(locked), 1); end
            step(0, 1'($urandom), 0, 0);
        end
        step(1, !prbs_next(), 0, 0);
        step(0, 1'($urandom), 0, 0);
        settle();
        chk("toggle_idle_no_pulse", int'(err_pulse), 0);
        chk("toggle_err_count", int'(err_count), 1);
        step(1, !prbs_next(), 1, 0);
        settle();
        chk("clear_pulse_kept", int'(err_pulse), 1);
        chk("clear_err_count", int'(err_count), 0);
        chk("clear_bit_count", int'(bit_count), 0);

        // reset while locked with err_count = 7
        do_reset();
        clean(13);
        for (int i = 0; i < 7; i++) begin
            flip();
            clean(15);
        end
        settle();
        chk("pre_rst_err_count", int'(err_count), 7);
        chk("pre_rst_locked", int'(locked), 1);
        step(0, 0, 0, 1);
        settle();
        chk("mid_rst_locked", int'(locked), 0);
        chk("mid_rst_err_count", int'(err_count), 0);
        chk("mid_rst_bit_count", int'(bit_count), 0);
        clean(12);
        settle();
        chk("post_rst_reseed", int'(locked), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) d = prbs_next() ^ ($urandom_range(0, 14) == 0);
            else   d = 1'($urandom);
            c = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 599) == 0);
            step(v, d, c, r);
        end
        step(0, 0, 0, 0);
        settle();
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
